// File: rtl/hbmc_rst_pkg.sv
// Shared definitions for the HyperBus reset sequencing logic: state encodings
// and the counter-width helper, also intended for clock-domain reset bridges.
package hbmc_rst_pkg;

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] IDLY_RST  = 3'd1;
    localparam logic [2:0] WAIT_RDY  = 3'd2;
    localparam logic [2:0] PHY_REL   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;

    typedef enum logic [2:0] {
        StWaitLock = WAIT_LOCK,
        StIdlyRst  = IDLY_RST,
        StWaitRdy  = WAIT_RDY,
        StPhyRel   = PHY_REL,
        StRun      = RUN
    } rst_state_e;

    // Width able to hold the largest of the three cycle counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hbmc_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
module hbmc_bit_sync #(
    parameter int unsigned C_SYNC_STAGES = 3,
    parameter logic        C_RESET_STATE = 1'b0
) (
    input  logic clk,
    input  logic arst,
    input  logic d_i,
    output logic q_o
);

    logic [C_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= {C_SYNC_STAGES{C_RESET_STATE}};
        end else begin
            sync_q <= {sync_q[C_SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[C_SYNC_STAGES-1];

endmodule

// File: rtl/hbmc_rst_sequencer.sv
// Bring-up controller: pulses the IDELAYCTRL reset, then releases PHY and controller
// resets in order once MMCM lock and IDELAYCTRL ready are seen; restarts on loss.
module hbmc_rst_sequencer
    import hbmc_rst_pkg::*;
#(
    parameter int unsigned C_SYNC_STAGES    = 3,
    parameter int unsigned C_IDELAY_RST_CYC = 16,
    parameter int unsigned C_RELEASE_GAP    = 8,
    parameter int unsigned C_TIMEOUT_CYC    = 65535
) (
    input  logic clk,
    input  logic arst,
    input  logic mmcm_locked_i,
    input  logic idelay_rdy_i,
    input  logic soft_rst_i,
    output logic rst_idelay_o,
    output logic rst_phy_o,
    output logic rst_ctrl_o,
    output logic init_done_o,
    output logic err_timeout_o
);

    localparam int unsigned CntW = cnt_width(C_IDELAY_RST_CYC, C_RELEASE_GAP, C_TIMEOUT_CYC);
    localparam logic [CntW-1:0] IdlyLast    = CntW'(C_IDELAY_RST_CYC - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(C_RELEASE_GAP - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(C_TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    logic locked_s;
    logic rdy_s;

    hbmc_bit_sync #(
        .C_SYNC_STAGES (C_SYNC_STAGES),
        .C_RESET_STATE (1'b0)
    ) u_sync_locked (
        .clk  (clk),
        .arst (arst),
        .d_i  (mmcm_locked_i),
        .q_o  (locked_s)
    );

    hbmc_bit_sync #(
        .C_SYNC_STAGES (C_SYNC_STAGES),
        .C_RESET_STATE (1'b0)
    ) u_sync_rdy (
        .clk  (clk),
        .arst (arst),
        .d_i  (idelay_rdy_i),
        .q_o  (rdy_s)
    );

    rst_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            rst_idelay_q;
    logic            rst_phy_q;
    logic            rst_ctrl_q;
    logic            init_done_q;
    logic            err_q;

    // One counter serves the pulse/gap timing and the wait timeout; it clears on every
    // state change, so the two uses never overlap.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            rst_idelay_q <= 1'b1;
            rst_phy_q    <= 1'b1;
            rst_ctrl_q   <= 1'b1;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else if (soft_rst_i) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            rst_idelay_q <= 1'b1;
            rst_phy_q    <= 1'b1;
            rst_ctrl_q   <= 1'b1;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else if (!locked_s && state_q != StWaitLock) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            rst_idelay_q <= 1'b1;
            rst_phy_q    <= 1'b1;
            rst_ctrl_q   <= 1'b1;
            init_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    if (locked_s) begin
                        state_q <= StIdlyRst;
                        cnt_q   <= '0;
                    end else if (cnt_q == TimeoutLast) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StIdlyRst: begin
                    if (cnt_q == IdlyLast) begin
                        state_q      <= StWaitRdy;
                        cnt_q        <= '0;
                        rst_idelay_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StWaitRdy: begin
                    if (rdy_s) begin
                        state_q   <= StPhyRel;
                        cnt_q     <= '0;
                        rst_phy_q <= 1'b0;
                    end else if (cnt_q == TimeoutLast) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StPhyRel: begin
                    if (cnt_q == GapLast) begin
                        state_q     <= StRun;
                        cnt_q       <= '0;
                        rst_ctrl_q  <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StRun: begin
                    if (!rdy_s) begin
                        state_q     <= StWaitRdy;
                        cnt_q       <= '0;
                        rst_phy_q   <= 1'b1;
                        rst_ctrl_q  <= 1'b1;
                        init_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= StWaitLock;
                    cnt_q        <= '0;
                    rst_idelay_q <= 1'b1;
                    rst_phy_q    <= 1'b1;
                    rst_ctrl_q   <= 1'b1;
                    init_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_idelay_o  = rst_idelay_q;
    assign rst_phy_o     = rst_phy_q;
    assign rst_ctrl_o    = rst_ctrl_q;
    assign init_done_o   = init_done_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_hbmc_rst_sequencer.sv
// Scoreboard bench for hbmc_rst_sequencer: expected output vectors are queued per cycle
// as stimulus is applied and compared when the simulation reaches that cycle.
module tb_hbmc_rst_sequencer;

    logic clk = 1'b0;
    logic arst;
    logic mmcm_locked;
    logic idelay_rdy;
    logic soft_rst;
    logic rst_idelay;
    logic rst_phy;
    logic rst_ctrl;
    logic init_done;
    logic err_timeout;

    hbmc_rst_sequencer dut (
        .clk           (clk),
        .arst          (arst),
        .mmcm_locked_i (mmcm_locked),
        .idelay_rdy_i  (idelay_rdy),
        .soft_rst_i    (soft_rst),
        .rst_idelay_o  (rst_idelay),
        .rst_phy_o     (rst_phy),
        .rst_ctrl_o    (rst_ctrl),
        .init_done_o   (init_done),
        .err_timeout_o (err_timeout)
    );

    always #5 clk = ~clk;

    // {rst_idelay, rst_phy, rst_ctrl, init_done, err_timeout}
    logic [4:0] obs;
    assign obs = {rst_idelay, rst_phy, rst_ctrl, init_done, err_timeout};

    typedef struct {
        string       name;
        int unsigned at;
        logic [4:0]  exp;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always @(negedge clk) begin
        if (arst === 1'b0) begin
            checks++;
            if ((rst_ctrl === 1'b0 && rst_phy !== 1'b0) ||
                (rst_phy === 1'b0 && rst_idelay !== 1'b0)) begin
                errors++;
                $display("FAIL reset_order: got idelay/phy/ctrl=%b%b%b at cycle %0d, required ordered",
                         rst_idelay, rst_phy, rst_ctrl, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic expect_at(input string name, input int unsigned at, input logic [4:0] v);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        exp_t        e;
        n = 0;
        while (exp_q.size() != 0) begin
            if (exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b required %b at cycle %0d", e.name, obs, e.exp, cyc);
                end
            end else if (exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: missed, got cycle %0d required cycle %0d", e.name, cyc, e.at);
            end else if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s: budget expired, got cycle %0d required cycle %0d",
                         exp_q[0].name, cyc, exp_q[0].at);
                exp_q.delete();
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        int unsigned b;
        arst        = 1'b1;
        mmcm_locked = 1'b1;
        idelay_rdy  = 1'b1;
        soft_rst    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 5'b11100) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", obs, 5'b11100);
        end
        arst = 1'b0;
        b = cyc;
        expect_at("t1_rel0",     b + 0,  5'b11100);
        expect_at("t1_sync",     b + 4,  5'b11100);
        expect_at("t1_idly_end", b + 19, 5'b11100);
        expect_at("t1_idly_off", b + 20, 5'b01100);
        expect_at("t1_phy_rel",  b + 21, 5'b00100);
        expect_at("t1_gap_end",  b + 28, 5'b00100);
        expect_at("t1_run",      b + 29, 5'b00010);
        drain(40);
    endtask

    task automatic test_timeout();
        int unsigned b;
        mmcm_locked = 1'b0;
        arst        = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        b = cyc;
        expect_at("t2_pre_to",  b + 65534, 5'b11100);
        expect_at("t2_to",      b + 65535, 5'b11101);
        expect_at("t2_sticky",  b + 70000, 5'b11101);
        drain(70010);
        mmcm_locked = 1'b1;
        b = cyc;
        expect_at("t2_idly_end", b + 19, 5'b11101);
        expect_at("t2_idly_off", b + 20, 5'b01101);
        expect_at("t2_phy_rel",  b + 21, 5'b00101);
        expect_at("t2_gap_end",  b + 28, 5'b00101);
        expect_at("t2_run",      b + 29, 5'b00011);
        drain(40);
    endtask

    task automatic test_lock_loss();
        int unsigned b;
        mmcm_locked = 1'b0;
        b = cyc;
        expect_at("t3_still_run", b + 3, 5'b00011);
        expect_at("t3_abort",     b + 4, 5'b11101);
        drain(10);
        mmcm_locked = 1'b1;
        b = cyc;
        expect_at("t3_wait",      b + 3,  5'b11101);
        expect_at("t3_idly_end",  b + 19, 5'b11101);
        expect_at("t3_idly_off",  b + 20, 5'b01101);
        expect_at("t3_phy_rel",   b + 21, 5'b00101);
        expect_at("t3_run",       b + 29, 5'b00011);
        drain(40);
    endtask

    task automatic test_rdy_drop();
        int unsigned b;
        idelay_rdy = 1'b0;
        b = cyc;
        expect_at("t4_still_run", b + 3, 5'b00011);
        expect_at("t4_wait_rdy",  b + 4, 5'b01101);
        expect_at("t4_hold",      b + 5, 5'b01101);
        drain(10);
        idelay_rdy = 1'b1;
        expect_at("t4_hold2",     b + 8,  5'b01101);
        expect_at("t4_phy_rel",   b + 9,  5'b00101);
        expect_at("t4_gap_end",   b + 16, 5'b00101);
        expect_at("t4_run",       b + 17, 5'b00011);
        drain(20);
    endtask

    task automatic test_soft_rst();
        int unsigned b;
        mmcm_locked = 1'b0;
        b = cyc;
        expect_at("t5_abort", b + 4, 5'b11101);
        drain(10);
        mmcm_locked = 1'b1;
        b = cyc;
        expect_at("t5_idly7", b + 11, 5'b11101);
        drain(20);
        soft_rst    = 1'b1;
        mmcm_locked = 1'b0;
        tick();
        soft_rst = 1'b0;
        expect_at("t5_soft",      b + 12, 5'b11100);
        expect_at("t5_held",      b + 20, 5'b11100);
        drain(12);
        mmcm_locked = 1'b1;
        b = cyc;
        expect_at("t5_idly_end",  b + 19, 5'b11100);
        expect_at("t5_idly_off",  b + 20, 5'b01100);
        expect_at("t5_phy_rel",   b + 21, 5'b00100);
        expect_at("t5_run",       b + 29, 5'b00010);
        drain(40);
    endtask

    task automatic test_arst_async();
        int unsigned b;
        idelay_rdy = 1'b0;
        tick();
        idelay_rdy = 1'b1;
        b = cyc - 1;
        expect_at("t6_wait_rdy", b + 4, 5'b01100);
        expect_at("t6_phy_rel",  b + 8, 5'b00100);
        drain(12);
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            errors++;
            $display("FAIL t6_async: got %b required %b", obs, 5'b11100);
        end
        @(negedge clk);
        checks++;
        if (obs !== 5'b11100) begin
            errors++;
            $display("FAIL t6_held: got %b required %b", obs, 5'b11100);
        end
        arst = 1'b0;
        b = cyc;
        expect_at("t6_rel0",     b + 0,  5'b11100);
        expect_at("t6_gap_end",  b + 28, 5'b00100);
        expect_at("t6_run",      b + 29, 5'b00010);
        drain(40);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_lock_loss();
        test_rdy_drop();
        test_soft_rst();
        test_arst_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
